fake_jpeg_19866_bist: RTL

Built-in self-test driver for the `fake_jpeg_19866_n_148` combinational netlist. It sits directly upstream and downstream of that netlist.
- Upstream: generates 45-bit pseudo-random stimulus vectors with an LFSR and drives them onto the netlist inputs `n_0`..`n_44`.
- Downstream: compacts the single netlist output `n_148` into a 16-bit CRC-style signature.

One vector is applied per clock, and a run ends with a `done` flag and a stable signature.

---
 rtl/fake_jpeg_19866_bist.sv | 107 ++++++++++
 1 files changed

// File: rtl/fake_jpeg_19866_bist.sv
// BIST driver: LFSR stimulus into the fake_jpeg_19866_n_148 netlist, MISR compaction of its output.
// One vector per clock; done/signature held until the next accepted start or reset.
module fake_jpeg_19866_bist #(
    parameter int VEC_W = 45,
    parameter int SIG_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_vectors_i,
    input  logic [VEC_W-1:0] seed_i,
    output logic [VEC_W-1:0] vec_out_o,
    input  logic             resp_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [SIG_W-1:0] signature_o,
    output logic [CNT_W-1:0] vec_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [SIG_W-1:0] SIG_POLY = SIG_W'(16'h1021);

    state_t           state_q, state_d;
    logic [VEC_W-1:0] lfsr_q, lfsr_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             start_ok;
    logic [CNT_W-1:0] cnt_inc;
    logic             lfsr_fb;

    assign start_ok = start_i && (state_q != S_RUN);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign lfsr_fb  = lfsr_q[VEC_W-1] ^ lfsr_q[VEC_W-2] ^ lfsr_q[VEC_W-4] ^ lfsr_q[VEC_W-5];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = (num_vectors_i != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (cnt_inc == num_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_o = (state_q == S_RUN);
        done_o = (state_q == S_DONE);
    end

    // Datapath next-state: a zero seed would lock the LFSR, so it is replaced by 1
    always_comb begin
        lfsr_d = lfsr_q;
        sig_d  = sig_q;
        cnt_d  = cnt_q;
        num_d  = num_q;
        if (start_ok) begin
            lfsr_d = (seed_i == '0) ? VEC_W'(1) : seed_i;
            sig_d  = '0;
            cnt_d  = '0;
            num_d  = num_vectors_i;
        end else if (state_q == S_RUN) begin
            lfsr_d = {lfsr_q[VEC_W-2:0], lfsr_fb};
            sig_d  = {sig_q[SIG_W-2:0], 1'b0} ^ ((sig_q[SIG_W-1] ^ resp_in_i) ? SIG_POLY : '0);
            cnt_d  = cnt_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= '0;
            sig_q  <= '0;
            cnt_q  <= '0;
            num_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            sig_q  <= sig_d;
            cnt_q  <= cnt_d;
            num_q  <= num_d;
        end
    end

    assign vec_out_o   = lfsr_q;
    assign signature_o = sig_q;
    assign vec_count_o = cnt_q;

endmodule
